bin_bram_ctrl: RTL and testbench
================================

# bin_bram_ctrl

Burst sequencer for one port of the bin manager's variable-state BRAM. It moves a contiguous block of words between the BRAM and the bin manager. A load drains `len` words starting at `base_addr` into a valid/ready stream. A store writes `len` words from a valid/ready stream into the BRAM. It sits between the bin load/store logic and the BRAM, absorbs the BRAM's 1-cycle read latency, and supports downstream backpressure without losing words.

## Interface
- `DATA_WIDTH`, 30: BRAM word width ({value, level, ...} packed by caller).
- `ADDR_WIDTH`, 10: BRAM address width; depth is 2^ADDR_WIDTH.
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `start_load` in 1: begin load burst; sampled only in IDLE.
- `start_store` in 1: begin store burst; sampled only in IDLE.
- `base_addr` in ADDR_WIDTH: first BRAM address; sampled with start.
- `len` in ADDR_WIDTH+1: word count, 0..2^ADDR_WIDTH; sampled with start.
- `busy` out 1: burst in progress.
- `done` out 1: one-cycle pulse at burst completion.
- `rd_valid` out 1, `rd_ready` in 1, `rd_data` out DATA_WIDTH: load output stream.
- `wr_valid` in 1, `wr_ready` out 1, `wr_data` in DATA_WIDTH: store input stream.
- `bram_we` out 1, `bram_addr` out ADDR_WIDTH, `bram_din` out DATA_WIDTH: BRAM port drive.
- `bram_dout` in DATA_WIDTH: BRAM read data, valid the cycle after its address.

## Operation
- States: IDLE, LOAD, STORE, DONE.
- IDLE → LOAD on `start_load`. IDLE → STORE on `start_store`. Both high selects LOAD; `start_store` is ignored.
- Starts outside IDLE are ignored.
- `base_addr` and `len` are latched at the start.
- `len`=0: go straight to DONE, with no BRAM access and no stream handshake.
- Address rule: `bram_addr` = latched base + index, modulo 2^ADDR_WIDTH. Wrap past the top address is legal.
- LOAD:
  - Issue counter `iss` and delivered counter `dlv` each count 0..len.
  - Holds a 2-entry output FIFO plus a 1-bit in-flight flag.
  - A read is issued (`bram_addr` = base+`iss`, `bram_we`=0) when `iss`<len and FIFO occupancy + in-flight − this cycle's pop ≤ 1.
  - Data returned on `bram_dout` is pushed into the FIFO the next cycle.
  - FIFO head drives `rd_data`/`rd_valid`. A pop happens on `rd_valid & rd_ready`.
  - `rd_data` stays stable while `rd_valid` is high and `rd_ready` is low.
  - Words are delivered in address order, with no drops and no duplicates.
  - LOAD → DONE on the pop that makes `dlv`=len.
- STORE:
  - `wr_ready`=1 while in STORE.
  - `bram_we` = `wr_valid`. `bram_addr` = base+index. `bram_din` = `wr_data`. All are combinational from the stream.
  - Index increments on each handshake.
  - STORE → DONE on the handshake with index = len−1.
- DONE: `done`=1 and `busy`=0 for exactly one cycle, then IDLE.
- `busy` is 1 in LOAD and STORE only.
- `rd_valid`=0 outside LOAD. `wr_ready`=0 outside STORE. `bram_we`=0 outside STORE.
- Reset, including mid-burst: state goes to IDLE, the FIFO is flushed, in-flight read data is discarded, and counters are cleared.

## Timing
- Reset values: `busy`=0, `done`=0, `rd_valid`=0, `rd_data`=0, `wr_ready`=0, `bram_we`=0, `bram_addr`=0, `bram_din`=0.
- Start sampled at edge E:
  - cycle E+1: `busy`=1 and the first read address is on `bram_addr`.
  - cycle E+2: first word on `bram_dout`.
  - cycle E+3: `rd_valid`=1 with word 0.
- Load with `rd_ready` held high sustains 1 word/cycle. A len-N load finishes its last pop at cycle E+N+2, with `done` at E+N+3.
- Store: `wr_ready` rises at E+1. A write commits at the edge ending each handshake cycle. `done` comes the cycle after the last handshake.
- `done` and a new start may not overlap. A start is first accepted in the IDLE cycle after `done`.

## Test plan
- **Store then load, no backpressure:** store base=5, len=4, data 0xA,0xB,0xC,0xD; then load the same range with `rd_ready`=1.
  - BRAM[5..8] = A..D.
  - Load stream is A,B,C,D on consecutive cycles starting at E+3.
  - `done` pulses once per burst.
- **Load backpressure:** base=0, len=6; `rd_ready` toggles 1,0,0,1,… pseudo-randomly.
  - Exactly 6 words in order.
  - `rd_data` is stable while stalled.
  - No more than 2 reads outstanding beyond FIFO capacity.
- **Wrap-around:** ADDR_WIDTH=10, store base=1022, len=4.
  - Writes land at 1022, 1023, 0, 1.
  - A load of the same range returns identical data.
- **Edge lengths:** len=0 → `done` at E+1 with no `bram_we`/`rd_valid`. len=1024 full-depth load → 1024 words, `done` once.
- **Simultaneous and illegal starts:** `start_load` and `start_store` high together → load performed. `start_store` pulsed mid-load → ignored, with no `bram_we`.
- **Reset mid-burst:** assert `rst` during a load at `dlv`=2 of len=8.
  - Next cycle all outputs equal their reset values and `busy`=0.
  - A subsequent load of len=3 returns the correct 3 words with no stale FIFO data.

Source files
------------

// File: rtl/bin_bram_ctrl.sv
// Burst sequencer for one BRAM port: streams len words out of the BRAM (load) or into it (store).
// Loads absorb the 1-cycle read latency with a 2-entry skid FIFO so backpressure never drops words.
module bin_bram_ctrl #(
  parameter int unsigned DATA_WIDTH = 30,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_load,
  input  logic                  start_store,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout
);

  localparam int unsigned CW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StStore, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CW-1:0]         len_q, iss_q, dlv_q;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic                  wptr_q, rptr_q;
  logic [1:0]            cnt_q;

  logic                  pop, push, issue, wr_hs, start_any;
  logic [2:0]            occ_next;

  assign start_any = start_load | start_store;
  assign push      = inflight_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a simultaneous start selects load
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_load) begin
          state_d = (len == '0) ? StDone : StLoad;
        end else if (start_store) begin
          state_d = (len == '0) ? StDone : StStore;
        end
      end
      StLoad: begin
        if (pop && (dlv_q == len_q - CW'(1))) state_d = StDone;
      end
      StStore: begin
        if (wr_hs && (iss_q == len_q - CW'(1))) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output and handshake decode
  always_comb begin
    busy      = (state_q == StLoad) || (state_q == StStore);
    done      = (state_q == StDone);
    rd_valid  = (state_q == StLoad) && (cnt_q != 2'd0);
    rd_data   = rd_valid ? fifo_q[rptr_q] : '0;
    pop       = rd_valid & rd_ready;
    wr_ready  = (state_q == StStore);
    wr_hs     = wr_ready & wr_valid;
    bram_we   = wr_hs;
    bram_din  = wr_ready ? wr_data : '0;
    bram_addr = busy ? base_q + iss_q[ADDR_WIDTH-1:0] : '0;
    // Occupancy after this cycle must leave room for a read issued now
    occ_next  = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = (state_q == StLoad) && (iss_q < len_q) && (occ_next <= 3'd1);
  end

  // Burst counters, in-flight flag and FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q     <= '0;
      len_q      <= '0;
      iss_q      <= '0;
      dlv_q      <= '0;
      inflight_q <= 1'b0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      if ((state_q == StIdle) && start_any) begin
        base_q <= base_addr;
        len_q  <= len;
        iss_q  <= '0;
        dlv_q  <= '0;
      end else begin
        if (issue || wr_hs) iss_q <= iss_q + CW'(1);
        if (pop)            dlv_q <= dlv_q + CW'(1);
      end
      inflight_q <= issue;
      if (push) wptr_q <= ~wptr_q;
      if (pop)  rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // FIFO storage needs no reset; rd_data is masked while empty
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= bram_dout;
  end

endmodule

// File: tb/tb_bin_bram_ctrl.sv
// Self-checking bench for bin_bram_ctrl with a behavioural BRAM and a load scoreboard.
module tb_bin_bram_ctrl;

  localparam int DW    = 30;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_load = 1'b0, start_store = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, rd_valid, wr_ready, bram_we;
  logic          rd_ready = 1'b0, wr_valid = 1'b0;
  logic [DW-1:0] rd_data, bram_din, bram_dout;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] bram_addr;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] q_exp [$];
  logic [DW-1:0] shadow [DEPTH];
  logic [DW-1:0] mem [DEPTH];
  logic          init_mem = 1'b1;

  always #5 clk = ~clk;

  bin_bram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_load  (start_load),
    .start_store (start_store),
    .base_addr   (base_addr),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .bram_we     (bram_we),
    .bram_addr   (bram_addr),
    .bram_din    (bram_din),
    .bram_dout   (bram_dout)
  );

  function automatic logic [DW-1:0] pat(int i);
    return DW'((i * 40503) ^ 32'h155);
  endfunction

  // Read-first BRAM with registered output
  always_ff @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= pat(i);
    end else if (bram_we) begin
      mem[bram_addr] <= bram_din;
    end
    bram_dout <= mem[bram_addr];
  end

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(string tag);
    @(negedge clk);
    check_eq({tag, "_busy"},      32'(busy),      32'd0);
    check_eq({tag, "_done"},      32'(done),      32'd0);
    check_eq({tag, "_rd_valid"},  32'(rd_valid),  32'd0);
    check_eq({tag, "_rd_data"},   32'(rd_data),   32'd0);
    check_eq({tag, "_wr_ready"},  32'(wr_ready),  32'd0);
    check_eq({tag, "_bram_we"},   32'(bram_we),   32'd0);
    check_eq({tag, "_bram_addr"}, 32'(bram_addr), 32'd0);
    check_eq({tag, "_bram_din"},  32'(bram_din),  32'd0);
  endtask

  task automatic do_store(int b, int n, logic [DW-1:0] d0, bit bubbles);
    logic [AW-1:0] a;
    start_store = 1'b1;
    base_addr   = AW'(b);
    len         = (AW+1)'(n);
    step();
    start_store = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (bubbles && $urandom_range(0, 2) == 0) begin
        wr_valid = 1'b0;
        @(negedge clk);
        check_eq("store_bubble_we", 32'(bram_we), 32'd0);
        step();
      end
      a         = AW'(b + i);
      wr_valid  = 1'b1;
      wr_data   = d0 + DW'(i);
      shadow[a] = d0 + DW'(i);
      @(negedge clk);
      check_eq("store_ready", 32'(wr_ready),  32'd1);
      check_eq("store_we",    32'(bram_we),   32'd1);
      check_eq("store_addr",  32'(bram_addr), 32'(a));
      check_eq("store_din",   32'(bram_din),  32'(d0 + DW'(i)));
      step();
    end
    wr_valid = 1'b0;
    @(negedge clk);
    check_eq("store_done",      32'(done),    32'd1);
    check_eq("store_done_busy", 32'(busy),    32'd0);
    check_eq("store_done_we",   32'(bram_we), 32'd0);
    step();
    @(negedge clk);
    check_eq("store_done_once", 32'(done), 32'd0);
  endtask

  task automatic do_load(int b, int n, bit bp, bit both, int poke, int abort_at,
                         output bit aborted);
    int            k, popped, first_k, done_k;
    bit            stalled, we_seen;
    logic [DW-1:0] held;
    for (int i = 0; i < n; i++) q_exp.push_back(shadow[AW'(b + i)]);
    start_load  = 1'b1;
    start_store = both;
    base_addr   = AW'(b);
    len         = (AW+1)'(n);
    step();
    start_load  = 1'b0;
    start_store = 1'b0;
    k = 1; popped = 0; first_k = -1; done_k = -1; stalled = 0; we_seen = 0; held = '0;
    aborted = 0;
    while (k < 4 * n + 40) begin
      rd_ready    = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      start_store = (k == poke);
      @(negedge clk);
      if (bram_we) we_seen = 1;
      if (stalled) begin
        check_eq("rd_valid_held",  32'(rd_valid), 32'd1);
        check_eq("rd_data_stable", 32'(rd_data),  32'(held));
      end
      if (rd_valid && rd_ready) begin
        if (q_exp.size() == 0) check_eq("extra_word", 32'(popped + 1), 32'(n));
        else check_eq("load_word", 32'(rd_data), 32'(q_exp.pop_front()));
        if (popped == 0) first_k = k;
        popped++;
      end
      stalled = rd_valid && !rd_ready;
      held    = rd_data;
      if (done) begin
        done_k = k;
        break;
      end
      if (abort_at != 0 && popped == abort_at) begin
        aborted = 1;
        break;
      end
      step();
      k++;
    end
    start_store = 1'b0;
    rd_ready    = 1'b0;
    if (aborted) return;
    check_eq("load_finished",   32'(done_k >= 0),   32'd1);
    check_eq("load_count",      32'(popped),        32'(n));
    check_eq("load_queue_left", 32'(q_exp.size()),  32'd0);
    check_eq("load_done_busy",  32'(busy),          32'd0);
    check_eq("load_no_we",      32'(we_seen),       32'd0);
    if (!bp) begin
      check_eq("load_done_cycle", 32'(done_k), (n == 0) ? 32'd1 : 32'(n + 3));
      if (n > 0) check_eq("load_first_cycle", 32'(first_k), 32'd3);
    end
    q_exp.delete();
    step();
    @(negedge clk);
    check_eq("load_done_once", 32'(done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ab;
    for (int i = 0; i < DEPTH; i++) shadow[i] = pat(i);
    step();
    init_mem = 1'b0;
    step();
    rst = 1'b0;
    check_reset_outputs("reset");
    step();

    // Store then load, no backpressure
    do_store(5, 4, DW'('hA), 1'b0);
    for (int i = 0; i < 4; i++) check_eq("store_mem", 32'(mem[5 + i]), 32'('hA + i));
    do_load(5, 4, 1'b0, 1'b0, 0, 0, ab);

    // Backpressured load, store with bubbles
    do_store(0, 6, DW'('h100), 1'b1);
    do_load(0, 6, 1'b1, 1'b0, 0, 0, ab);

    // Wrap-around at the top of the address space
    do_store(1022, 4, DW'('h2000), 1'b0);
    check_eq("wrap_1022", 32'(mem[1022]), 32'h2000);
    check_eq("wrap_1023", 32'(mem[1023]), 32'h2001);
    check_eq("wrap_0",    32'(mem[0]),    32'h2002);
    check_eq("wrap_1",    32'(mem[1]),    32'h2003);
    do_load(1022, 4, 1'b0, 1'b0, 0, 0, ab);

    // Edge lengths
    do_store(9, 0, DW'('h55), 1'b0);
    do_load(9, 0, 1'b0, 1'b0, 0, 0, ab);
    do_load(0, DEPTH, 1'b0, 1'b0, 0, 0, ab);

    // Simultaneous starts and a store start during a load
    do_load(20, 5, 1'b0, 1'b1, 0, 0, ab);
    do_load(30, 8, 1'b0, 1'b0, 4, 0, ab);
    do_load(60, 10, 1'b1, 1'b0, 3, 0, ab);

    // Reset mid-burst after two words delivered
    do_load(40, 8, 1'b0, 1'b0, 0, 2, ab);
    check_eq("abort_reached", 32'(ab), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("mid_reset");
    q_exp.delete();
    step();
    do_load(50, 3, 1'b0, 1'b0, 0, 0, ab);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
